// File: rtl/apb_master.sv
// APB requester: turns single-beat commands into APB SETUP/ACCESS transfers, with a wait-state watchdog.
// Latency: a zero-wait transfer responds 2 cycles after accept; the next command can be accepted in the response cycle.
// Backpressure: cmd_ready is high only in IDLE (no queueing); PREADY low stretches ACCESS until the watchdog aborts.
module apb_master #(
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                  PCLK,
    input  logic                  PRESET,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic                  cmd_write,
    input  logic [ADDR_WIDTH-1:0] cmd_addr,
    input  logic [DATA_WIDTH-1:0] cmd_wdata,
    output logic                  rsp_valid,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic                  rsp_err,
    output logic                  rsp_timeout,
    output logic                  busy,
    output logic                  PSEL,
    output logic                  PENABLE,
    output logic                  PWRITE,
    output logic [ADDR_WIDTH-1:0] PADDR,
    output logic [DATA_WIDTH-1:0] PWDATA,
    input  logic [DATA_WIDTH-1:0] PRDATA,
    input  logic                  PREADY,
    input  logic                  PSLVERR
);

    // Counter just wide enough to reach TIMEOUT_CYCLES; at least one bit when the watchdog is off.
    localparam int CW = (TIMEOUT_CYCLES < 1) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
    localparam bit WDOG_EN = (TIMEOUT_CYCLES != 0);
    // Count value seen on the edge of the TIMEOUT_CYCLES-th consecutive low-PREADY cycle.
    localparam logic [CW-1:0] TO_LAST = WDOG_EN ? CW'(TIMEOUT_CYCLES - 1) : '0;

    typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;

    state_t                state, nxt_state;
    logic [CW-1:0]         wait_cnt, nxt_wait_cnt;
    logic                  nxt_psel, nxt_penable, nxt_pwrite;
    logic [ADDR_WIDTH-1:0] nxt_paddr;
    logic [DATA_WIDTH-1:0] nxt_pwdata;
    logic                  nxt_rsp_valid, nxt_rsp_err, nxt_rsp_timeout;
    logic [DATA_WIDTH-1:0] nxt_rsp_rdata;

    assign cmd_ready = (state == IDLE);
    assign busy      = (state != IDLE);

    // Next-state and next-output logic; every register holds unless a state says otherwise.
    always_comb begin
        nxt_state       = state;
        nxt_wait_cnt    = wait_cnt;
        nxt_psel        = PSEL;
        nxt_penable     = PENABLE;
        nxt_pwrite      = PWRITE;
        nxt_paddr       = PADDR;
        nxt_pwdata      = PWDATA;
        nxt_rsp_valid   = 1'b0;
        nxt_rsp_rdata   = rsp_rdata;
        nxt_rsp_err     = rsp_err;
        nxt_rsp_timeout = rsp_timeout;
        case (state)
            IDLE: begin
                if (cmd_valid) begin
                    nxt_paddr   = cmd_addr;
                    nxt_pwdata  = cmd_wdata;
                    nxt_pwrite  = cmd_write;
                    nxt_psel    = 1'b1;
                    nxt_penable = 1'b0;
                    nxt_state   = SETUP;
                end
            end
            SETUP: begin
                nxt_penable  = 1'b1;
                nxt_wait_cnt = '0;
                nxt_state    = ACCESS;
            end
            ACCESS: begin
                if (PREADY) begin
                    // PRDATA/PSLVERR only matter on the completing edge.
                    nxt_rsp_valid   = 1'b1;
                    nxt_rsp_rdata   = PWRITE ? '0 : PRDATA;
                    nxt_rsp_err     = PSLVERR;
                    nxt_rsp_timeout = 1'b0;
                    nxt_psel        = 1'b0;
                    nxt_penable     = 1'b0;
                    nxt_state       = IDLE;
                end else begin
                    if (wait_cnt != '1) begin
                        nxt_wait_cnt = wait_cnt + CW'(1);
                    end
                    if (WDOG_EN && (wait_cnt == TO_LAST)) begin
                        nxt_rsp_valid   = 1'b1;
                        nxt_rsp_rdata   = '0;
                        nxt_rsp_err     = 1'b1;
                        nxt_rsp_timeout = 1'b1;
                        nxt_psel        = 1'b0;
                        nxt_penable     = 1'b0;
                        nxt_state       = IDLE;
                    end
                end
            end
            default: begin
                nxt_psel    = 1'b0;
                nxt_penable = 1'b0;
                nxt_state   = IDLE;
            end
        endcase
    end

    // State and registered outputs; reset drops any transfer in flight without a response.
    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            state       <= IDLE;
            wait_cnt    <= '0;
            PSEL        <= 1'b0;
            PENABLE     <= 1'b0;
            PWRITE      <= 1'b0;
            PADDR       <= '0;
            PWDATA      <= '0;
            rsp_valid   <= 1'b0;
            rsp_rdata   <= '0;
            rsp_err     <= 1'b0;
            rsp_timeout <= 1'b0;
        end else begin
            state       <= nxt_state;
            wait_cnt    <= nxt_wait_cnt;
            PSEL        <= nxt_psel;
            PENABLE     <= nxt_penable;
            PWRITE      <= nxt_pwrite;
            PADDR       <= nxt_paddr;
            PWDATA      <= nxt_pwdata;
            rsp_valid   <= nxt_rsp_valid;
            rsp_rdata   <= nxt_rsp_rdata;
            rsp_err     <= nxt_rsp_err;
            rsp_timeout <= nxt_rsp_timeout;
        end
    end

endmodule

// File: tb/tb_apb_master.sv
// Directed bench for apb_master: write, waited read, slave error, watchdog abort, back-to-back, async reset.
// Inputs change 1ns after the rising edge and outputs are sampled there too, away from the active edge.
// The bench plays the APB slave directly by driving PREADY/PRDATA/PSLVERR.
module tb_apb_master;

    logic        PCLK = 1'b0;
    logic        PRESET;
    logic        cmd_valid, cmd_ready, cmd_write;
    logic [31:0] cmd_addr, cmd_wdata;
    logic        rsp_valid, rsp_err, rsp_timeout, busy;
    logic [31:0] rsp_rdata;
    logic        PSEL, PENABLE, PWRITE;
    logic [31:0] PADDR, PWDATA, PRDATA;
    logic        PREADY, PSLVERR;

    int checks   = 0;
    int failures = 0;
    int rsp_cnt;

    apb_master #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .TIMEOUT_CYCLES(16)) dut (
        .PCLK(PCLK), .PRESET(PRESET),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .rsp_timeout(rsp_timeout), .busy(busy),
        .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE), .PADDR(PADDR),
        .PWDATA(PWDATA), .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR)
    );

    always #5 PCLK = ~PCLK;

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation still running at %0t, required finish earlier", $time);
        $fatal(1, "bench time limit reached");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge PCLK);
        #1;
    endtask

    // One complete transfer with nwait low-PREADY cycles; PSLVERR/PRDATA carry junk while waiting.
    task automatic do_xfer(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                           input int nwait, input logic [31:0] rd, input logic err);
        cmd_valid = 1'b1; cmd_write = wr; cmd_addr = addr; cmd_wdata = wdata;
        PREADY = 1'b0; PSLVERR = 1'b0;
        chk("x_ready_idle", cmd_ready, 1);
        tick();
        cmd_valid = 1'b0;
        chk("x_setup_psel", PSEL, 1);
        chk("x_setup_penable", PENABLE, 0);
        chk("x_setup_busy", busy, 1);
        chk("x_setup_ready", cmd_ready, 0);
        chk("x_paddr", PADDR, addr);
        chk("x_pwrite", PWRITE, wr);
        chk("x_pwdata", PWDATA, wdata);
        tick();
        chk("x_access_psel", PSEL, 1);
        chk("x_access_penable", PENABLE, 1);
        for (int k = 0; k < nwait; k++) begin
            PREADY = 1'b0; PSLVERR = ~err; PRDATA = ~rd;
            tick();
            chk("x_wait_psel", PSEL, 1);
            chk("x_wait_penable", PENABLE, 1);
            chk("x_wait_paddr", PADDR, addr);
            chk("x_wait_pwrite", PWRITE, wr);
            chk("x_wait_rsp", rsp_valid, 0);
        end
        PREADY = 1'b1; PSLVERR = err; PRDATA = rd;
        tick();
        PREADY = 1'b0; PSLVERR = 1'b0; PRDATA = 32'h5555_AAAA;
        chk("x_rsp_valid", rsp_valid, 1);
        chk("x_rsp_rdata", rsp_rdata, wr ? 32'h0 : rd);
        chk("x_rsp_err", rsp_err, err);
        chk("x_rsp_timeout", rsp_timeout, 0);
        chk("x_done_psel", PSEL, 0);
        chk("x_done_penable", PENABLE, 0);
        chk("x_done_ready", cmd_ready, 1);
    endtask

    initial begin
        PRESET = 1'b1; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_wdata = '0;
        PRDATA = '0; PREADY = 1'b0; PSLVERR = 1'b0;
        tick(); tick();
        chk("rst_psel", PSEL, 0);
        chk("rst_penable", PENABLE, 0);
        chk("rst_busy", busy, 0);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_paddr", PADDR, 0);
        chk("rst_cmd_ready", cmd_ready, 1);
        PRESET = 1'b0;
        tick();

        // Zero-wait write of 0xA5C to the config register.
        do_xfer(1'b1, 32'h00, 32'h0000_0A5C, 0, 32'h0, 1'b0);
        tick();
        chk("w_pulse_end", rsp_valid, 0);
        chk("w_pwdata_hold", PWDATA, 32'h0000_0A5C);

        // Write to TX data with an error at completion, PSLVERR flipping during waits.
        do_xfer(1'b1, 32'h04, 32'h0000_0011, 2, 32'h0, 1'b1);
        tick();
        // Error asserted only during waits must not leak into the response.
        do_xfer(1'b1, 32'h04, 32'h0000_0022, 3, 32'h0, 1'b0);
        tick();

        // Read RX data after 3 wait states.
        do_xfer(1'b0, 32'h08, 32'h0, 3, 32'hDEAD_BEEF, 1'b0);
        tick();
        chk("r_rdata_hold", rsp_rdata, 32'hDEAD_BEEF);

        // Slave never ready: abort after exactly 16 ACCESS cycles.
        cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 32'h08;
        PREADY = 1'b0;
        tick();
        cmd_valid = 1'b0;
        tick();
        chk("to_access", PENABLE, 1);
        for (int k = 1; k < 16; k++) begin
            tick();
            chk("to_still_waiting", PSEL, 1);
            chk("to_no_rsp", rsp_valid, 0);
        end
        tick();
        chk("to_rsp_valid", rsp_valid, 1);
        chk("to_rsp_err", rsp_err, 1);
        chk("to_rsp_timeout", rsp_timeout, 1);
        chk("to_rsp_rdata", rsp_rdata, 0);
        chk("to_psel", PSEL, 0);
        chk("to_penable", PENABLE, 0);
        chk("to_ready", cmd_ready, 1);
        tick();
        chk("to_pulse_end", rsp_valid, 0);
        do_xfer(1'b0, 32'h00, 32'h0, 0, 32'h0000_00C3, 1'b0);
        tick();

        // Back-to-back: cmd_valid held for three accepts against a zero-wait slave.
        PREADY = 1'b1;
        rsp_cnt = 0;
        for (int i = 0; i < 10; i++) begin
            cmd_valid = (i <= 6); cmd_write = 1'b1; cmd_addr = 32'(i * 4); cmd_wdata = 32'(i);
            chk("b2b_ready", cmd_ready, (i % 3) == 0);
            chk("b2b_busy", busy, (i % 3) != 0);
            chk("b2b_rsp", rsp_valid, ((i % 3) == 0) && (i > 0));
            if (rsp_valid) rsp_cnt++;
            tick();
        end
        cmd_valid = 1'b0; PREADY = 1'b0;
        chk("b2b_rsp_count", rsp_cnt, 3);
        tick();

        // Asynchronous reset in the middle of ACCESS.
        cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 32'h08;
        tick();
        cmd_valid = 1'b0;
        tick();
        tick();
        chk("ar_in_access", PENABLE, 1);
        #2;
        PRESET = 1'b1;
        #1;
        chk("ar_psel_now", PSEL, 0);
        chk("ar_penable_now", PENABLE, 0);
        chk("ar_busy_now", busy, 0);
        chk("ar_rsp_now", rsp_valid, 0);
        tick();
        chk("ar_rsp_held", rsp_valid, 0);
        PRESET = 1'b0;
        chk("ar_ready", cmd_ready, 1);
        tick();
        chk("ar_no_rsp", rsp_valid, 0);
        do_xfer(1'b0, 32'h08, 32'h0, 1, 32'h1234_5678, 1'b0);
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/apb_master.md
Name: apb_master

Overview:
- APB (AMBA 3) requester: converts single-beat commands from a local controller or bus bridge into APB SETUP/ACCESS transfers.
- Its APB pins connect to peripheral slaves such as the I2C APB slave (config/status at 0x00, TX data at 0x04, RX data at 0x08).
- Returns one response per command carrying read data, slave error and a timeout flag.
- Adds a wait-state watchdog so a slave that never asserts PREADY cannot hang the requester.

Parameters:
ADDR_WIDTH, 32, width of cmd_addr and PADDR
DATA_WIDTH, 32, width of write/read data paths
TIMEOUT_CYCLES, 16, number of consecutive ACCESS cycles with PREADY low before abort; 0 disables the watchdog

Ports:
PCLK  input  1  clock; all logic on rising edge
PRESET  input  1  reset, asynchronous, active-high
cmd_valid  input  1  command request
cmd_ready  output  1  command accepted when cmd_valid && cmd_ready at a PCLK edge
cmd_write  input  1  1 = write, 0 = read
cmd_addr  input  ADDR_WIDTH  target address
cmd_wdata  input  DATA_WIDTH  write data (ignored for reads)
rsp_valid  output  1  one-cycle pulse: transfer finished
rsp_rdata  output  DATA_WIDTH  read data; 0 for writes and timeouts
rsp_err  output  1  PSLVERR sampled at completion, or 1 on timeout
rsp_timeout  output  1  1 when the transfer was aborted by the watchdog
busy  output  1  high in SETUP and ACCESS
PSEL  output  1  APB select
PENABLE  output  1  APB enable
PWRITE  output  1  APB direction
PADDR  output  ADDR_WIDTH  APB address
PWDATA  output  DATA_WIDTH  APB write data
PRDATA  input  DATA_WIDTH  APB read data
PREADY  input  1  APB ready
PSLVERR  input  1  APB slave error

Behaviour:
- Reset (asynchronous, immediate):
  - state = IDLE; every output = 0 (cmd_ready follows state, so it is 1 once IDLE).
  - Wait counter = 0.
  - A transfer in flight is dropped: PSEL/PENABLE fall without a PCLK edge, and no rsp_valid is issued for it.
- FSM states: IDLE, SETUP, ACCESS. All APB outputs and rsp_* are registered.
- cmd_ready = (state == IDLE), combinational from state only. No command queueing.
- IDLE: on accept, register cmd_addr/cmd_wdata/cmd_write into PADDR/PWDATA/PWRITE, set PSEL = 1 and PENABLE = 0, go to SETUP.
- SETUP: exactly one cycle. Set PENABLE = 1, clear the wait counter, go to ACCESS.
- ACCESS, PREADY = 1 at the edge:
  - Capture the response: rsp_rdata = PWRITE ? 0 : PRDATA; rsp_err = PSLVERR; rsp_timeout = 0.
  - rsp_valid = 1 for the next cycle only.
  - PSEL = 0, PENABLE = 0, go to IDLE.
- ACCESS, PREADY = 0 at the edge:
  - Hold PSEL, PENABLE, PADDR, PWRITE, PWDATA stable; increment the wait counter.
  - If TIMEOUT_CYCLES != 0 and this is the TIMEOUT_CYCLES-th consecutive low-PREADY cycle: abort. rsp_valid = 1, rsp_err = 1, rsp_timeout = 1, rsp_rdata = 0; PSEL = PENABLE = 0; go to IDLE.
- PADDR, PWRITE and PWDATA keep their last values in IDLE; they change only on accept.
- PSLVERR and PRDATA are ignored except at the completing edge (PREADY = 1 in ACCESS).
- Latency:
  - Zero-wait transfer: accept edge N, SETUP during N..N+1, ACCESS N+1..N+2, rsp_valid during N+2..N+3.
  - Next accept possible at edge N+3, so back-to-back throughput is 1 transfer per 3 cycles.
- rsp_valid coincides with cmd_ready = 1, so a new command may be accepted in the response cycle.
- Wait counter width: clog2(TIMEOUT_CYCLES+1), minimum 1 bit. The counter saturates, never wraps.

Test Plan:
- Write 0x00000A5C to 0x00, PREADY tied high -> PSEL high 2 cycles, PENABLE high in the 2nd, PWRITE=1, PWDATA=0x00000A5C; rsp_valid 1 cycle later with rsp_err=0, rsp_rdata=0.
- Read 0x08, slave gives PRDATA=0xDEADBEEF after 3 wait cycles -> PSEL/PENABLE/PADDR stable throughout; rsp_rdata=0xDEADBEEF, rsp_err=0, rsp_timeout=0.
- Write 0x04 with PSLVERR=1 at completion -> rsp_err=1, rsp_timeout=0; PSLVERR toggling during wait states has no effect.
- PREADY held 0, TIMEOUT_CYCLES=16 -> exactly 16 ACCESS cycles, then abort: rsp_valid, rsp_err=1, rsp_timeout=1, PSEL=0; next command accepted normally.
- cmd_valid held high for 3 commands, zero-wait slave -> accepts every 3rd cycle, 3 rsp_valid pulses, cmd_ready low whenever busy=1.
- PRESET asserted mid-ACCESS between edges -> PSEL, PENABLE, busy go 0 immediately; no rsp_valid; after release cmd_ready=1 and a new read completes.
